program_loader: RTL

//  Upstream feeder of the 16x8 program memory. Receives a program over a 2-wire

---
 rtl/program_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Serial program loader: assembles MSB-first bytes from an async 2-wire link,
// writes them to sequential memory addresses and holds the CPU while loading.
module program_loader #(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic              ser_clk,
    input  logic              ser_data,
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_opcode,
    output logic [3:0]        mem_immediate,
    output logic              mem_write,
    output logic              cpu_run,
    output logic              busy,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'((1 << ADDR_W) - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_LOAD,
        ST_WRITE,
        ST_DONE
    } state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_load_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_sdat_sync;
    logic                   r_sclk_q;
    logic [ADDR_W-1:0]      r_load_addr;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic [ADDR_W:0]        r_word_count;
    logic                   r_mem_write;
    logic                   r_cpu_run;
    logic                   r_busy;

    logic w_load_s;
    logic w_sdat_s;
    logic w_ser_rise;

    assign w_load_s   = r_load_sync[SYNC_STAGES-1];
    assign w_sdat_s   = r_sdat_sync[SYNC_STAGES-1];
    assign w_ser_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_q;

    // Equal-depth synchronizers keep ser_data aligned with the ser_clk edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_load_sync <= '0;
            r_sclk_sync <= '0;
            r_sdat_sync <= '0;
            r_sclk_q    <= 1'b0;
        end else begin
            r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load_en};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], ser_clk};
            r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], ser_data};
            r_sclk_q    <= r_sclk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_load_addr  <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_word_count <= '0;
            r_mem_write  <= 1'b0;
            r_cpu_run    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_load_s) begin
                        r_state      <= ST_LOAD;
                        r_load_addr  <= '0;
                        r_bit_cnt    <= '0;
                        r_word_count <= '0;
                        r_cpu_run    <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_cpu_run <= 1'b1;
                        r_busy    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Abort is tested first so it beats a coincident 8th bit.
                    if (!w_load_s) begin
                        r_state   <= ST_RUN;
                        r_cpu_run <= 1'b1;
                        r_busy    <= 1'b0;
                    end else if (w_ser_rise) begin
                        r_shift   <= {r_shift[6:0], w_sdat_s};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state     <= ST_WRITE;
                            r_mem_write <= 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    r_mem_write  <= 1'b0;
                    r_load_addr  <= r_load_addr + ADDR_W'(1);
                    r_word_count <= r_word_count + (ADDR_W+1)'(1);
                    if (r_word_count == LAST_WORD) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end else if (!w_load_s) begin
                        r_state   <= ST_RUN;
                        r_cpu_run <= 1'b1;
                        r_busy    <= 1'b0;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (!w_load_s) begin
                        r_state   <= ST_RUN;
                        r_cpu_run <= 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign mem_address   = r_cpu_run ? pc : r_load_addr;
    assign mem_opcode    = r_shift[3:0];
    assign mem_immediate = r_shift[7:4];
    assign mem_write     = r_mem_write;
    assign cpu_run       = r_cpu_run;
    assign busy          = r_busy;
    assign word_count    = r_word_count;

endmodule
